// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle ALU: grant, hold operands, capture, respond.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0).
module alu_arbiter #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic [3:0]  req0_cmd,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   input  logic [3:0]  req1_cmd,

   output logic [7:0]  alu_a_in,
   output logic [7:0]  alu_b_in,
   output logic [3:0]  alu_command_in,
   output logic        alu_oe,
   input  logic [15:0] alu_d_out,

   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [15:0] resp_data,
   output logic [15:0] ops_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] ops_done_q;
   logic        gnt;
   logic        accept;
   logic        resp_fire;

`ifdef ALU_ARB_RR_EN
   logic last_q;

   // On contention favour the requester that did not win last time.
   always_comb begin
      if (req0_valid && req1_valid) begin
         gnt = ~last_q;
      end else begin
         gnt = ~req0_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (accept) begin
         last_q <= gnt;
      end
   end
`else
   assign gnt = ~req0_valid;
`endif

   // Gated by rst_n so no ready leaks out while reset is held.
   assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = accept && !gnt;
   assign req1_ready = accept && gnt;

   assign alu_oe     = (state_q == EXEC);
   assign resp_valid = (state_q == RESP);
   assign resp_fire  = resp_valid && resp_ready;
   assign ops_done   = ops_done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               cnt_d   = LAT_M1;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operands are latched on acceptance and stay put until the next acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_in       <= 8'd0;
         alu_b_in       <= 8'd0;
         alu_command_in <= 4'd0;
         resp_id        <= 1'b0;
      end else if (accept) begin
         alu_a_in       <= gnt ? req1_a   : req0_a;
         alu_b_in       <= gnt ? req1_b   : req0_b;
         alu_command_in <= gnt ? req1_cmd : req0_cmd;
         resp_id        <= gnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_data <= 16'd0;
      end else if ((state_q == EXEC) && (cnt_q == 4'd0)) begin
         resp_data <= alu_d_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_done_q <= 16'd0;
      end else if (resp_fire) begin
         ops_done_q <= ops_done_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1 with an arithmetic stub,
// one at ALU_LAT=3 with a stub that counts EXEC cycles.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;

   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_cmd, req1_cmd;
   logic [7:0]  alu_a_in, alu_b_in;
   logic [3:0]  alu_cmd;
   logic        alu_oe;
   logic [15:0] alu_d_out;
   logic        resp_valid, resp_ready, resp_id;
   logic [15:0] resp_data, ops_done;

   logic        l3_req0_valid, l3_req0_ready, l3_req1_valid, l3_req1_ready;
   logic [7:0]  l3_req0_a, l3_req0_b, l3_req1_a, l3_req1_b;
   logic [3:0]  l3_req0_cmd, l3_req1_cmd;
   logic [7:0]  l3_alu_a_in, l3_alu_b_in;
   logic [3:0]  l3_alu_cmd;
   logic        l3_alu_oe;
   logic [15:0] l3_alu_d_out, l3_cnt;
   logic        l3_resp_valid, l3_resp_ready, l3_resp_id;
   logic [15:0] l3_resp_data, l3_ops_done;

   int n_checks = 0;
   int n_pass   = 0;

   alu_arbiter #(.ALU_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
      .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_command_in(alu_cmd),
      .alu_oe(alu_oe), .alu_d_out(alu_d_out),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .ops_done(ops_done)
   );

   alu_arbiter #(.ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready),
      .req0_a(l3_req0_a), .req0_b(l3_req0_b), .req0_cmd(l3_req0_cmd),
      .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready),
      .req1_a(l3_req1_a), .req1_b(l3_req1_b), .req1_cmd(l3_req1_cmd),
      .alu_a_in(l3_alu_a_in), .alu_b_in(l3_alu_b_in), .alu_command_in(l3_alu_cmd),
      .alu_oe(l3_alu_oe), .alu_d_out(l3_alu_d_out),
      .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready), .resp_id(l3_resp_id),
      .resp_data(l3_resp_data), .ops_done(l3_ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub: cmd 0 add, cmd 1 subtract, otherwise xor.
   always_comb begin
      case (alu_cmd)
         4'd0:    alu_d_out = {8'd0, alu_a_in} + {8'd0, alu_b_in};
         4'd1:    alu_d_out = {8'd0, alu_a_in} - {8'd0, alu_b_in};
         default: alu_d_out = {8'd0, alu_a_in ^ alu_b_in};
      endcase
   end

   // Slow stub: output is 1, 2, 3 ... on successive EXEC cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         l3_cnt <= 16'd0;
      else if (l3_alu_oe) l3_cnt <= l3_cnt + 16'd1;
      else                l3_cnt <= 16'd0;
   end
   assign l3_alu_d_out = l3_cnt + 16'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int grants[4];
      int acc_cyc[4];
      int n_gr;
      int both;
      int bad;
      int seen;
      int exp_g;

      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'd0; req0_b = 8'd0; req0_cmd = 4'd0;
      req1_a = 8'd0; req1_b = 8'd0; req1_cmd = 4'd0;
      resp_ready = 1'b1;
      l3_req0_valid = 1'b0; l3_req1_valid = 1'b0;
      l3_req0_a = 8'd0; l3_req0_b = 8'd0; l3_req0_cmd = 4'd0;
      l3_req1_a = 8'd0; l3_req1_b = 8'd0; l3_req1_cmd = 4'd0;
      l3_resp_ready = 1'b1;

      // Reset state, with both requesters valid to prove ready is held off.
      repeat (2) @(negedge clk);
      #1;
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      check("rst_alu_oe", 32'(alu_oe), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_alu_a", 32'(alu_a_in), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_ops_done", 32'(ops_done), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;

      // Single operation: 50 + 10 = 0x3C.
      @(negedge clk);
      req0_a = 8'd50; req0_b = 8'd10; req0_cmd = 4'd0; req0_valid = 1'b1;
      #1;
      check("t1_req0_ready", 32'(req0_ready), 32'd1);
      check("t1_req1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      check("t1_exec_oe", 32'(alu_oe), 32'd1);
      check("t1_exec_a", 32'(alu_a_in), 32'd50);
      check("t1_exec_b", 32'(alu_b_in), 32'd10);
      check("t1_exec_ready", 32'(req0_ready), 32'd0);
      @(negedge clk);
      #1;
      check("t1_resp_valid", 32'(resp_valid), 32'd1);
      check("t1_resp_id", 32'(resp_id), 32'd0);
      check("t1_resp_data", 32'(resp_data), 32'h3C);
      check("t1_resp_oe", 32'(alu_oe), 32'd0);
      @(negedge clk);
      #1;
      check("t1_idle_valid", 32'(resp_valid), 32'd0);
      check("t1_ops_done", 32'(ops_done), 32'd1);

      // Contention: both valid continuously for four grants, fresh reset first.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0_a = 8'd7; req0_b = 8'd3; req0_cmd = 4'd1;   // 4
      req1_a = 8'd5; req1_b = 8'd6; req1_cmd = 4'd0;   // 11
      req0_valid = 1'b1; req1_valid = 1'b1;
      n_gr = 0; both = 0;
      for (int cyc = 0; cyc < 40 && n_gr < 4; cyc++) begin
         #1;
         if (req0_ready && req1_ready) both++;
         if (req0_ready) begin grants[n_gr] = 0; acc_cyc[n_gr] = cyc; n_gr++; end
         else if (req1_ready) begin grants[n_gr] = 1; acc_cyc[n_gr] = cyc; n_gr++; end
         if (resp_valid) check("t2_resp_data", 32'(resp_data), resp_id ? 32'd11 : 32'd4);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("t2_grant_count", 32'(n_gr), 32'd4);
      check("t2_both_ready", 32'(both), 32'd0);
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         exp_g = i % 2;
`else
         exp_g = 0;
`endif
         if (i < n_gr) check($sformatf("t2_grant%0d", i), 32'(grants[i]), 32'(exp_g));
      end
      if (n_gr >= 2) check("t2_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      repeat (3) @(negedge clk);
      #1;
      check("t2_ops_done", 32'(ops_done), 32'd4);

      // Backpressure: hold resp_ready low for 5 cycles while req1 waits.
      @(negedge clk);
      resp_ready = 1'b0;
      req0_a = 8'd9; req0_b = 8'd4; req0_cmd = 4'd2;   // 9 ^ 4 = 13
      req0_valid = 1'b1;
      #1;
      check("t3_req0_ready", 32'(req0_ready), 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_a = 8'd1; req1_b = 8'd2; req1_cmd = 4'd0;   // 3
      req1_valid = 1'b1;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (resp_valid !== 1'b1 || resp_data !== 16'd13 || resp_id !== 1'b0) bad++;
         if (req0_ready || req1_ready) bad++;
         if (i == 1) req0_valid = 1'b1;
         if (i == 3) req0_valid = 1'b0;
         @(negedge clk);
      end
      check("t3_stall_bad", 32'(bad), 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("t3_req1_ready", 32'(req1_ready), 32'd1);
      check("t3_req0_dropped", 32'(req0_ready), 32'd0);
      check("t3_ops_done", 32'(ops_done), 32'd5);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      #1;
      check("t3_resp_id", 32'(resp_id), 32'd1);
      check("t3_resp_data", 32'(resp_data), 32'd3);
      @(negedge clk);

      // ALU_LAT=3 instance: capture on last EXEC cycle, five-cycle issue spacing.
      l3_req0_a = 8'd1; l3_req0_b = 8'd1; l3_req0_cmd = 4'd0;
      l3_req0_valid = 1'b1;
      n_gr = 0; seen = 0;
      for (int cyc = 0; cyc < 30 && n_gr < 2; cyc++) begin
         #1;
         if (l3_req0_ready) begin acc_cyc[n_gr] = cyc; n_gr++; end
         if (l3_resp_valid) begin
            seen++;
            check("t4_resp_data", 32'(l3_resp_data), 32'd3);
         end
         @(negedge clk);
      end
      l3_req0_valid = 1'b0;
      check("t4_accepts", 32'(n_gr), 32'd2);
      check("t4_resp_seen", 32'(seen), 32'd1);
      if (n_gr == 2) check("t4_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      repeat (3) @(negedge clk);
      #1;
      check("t4_resp2_valid", 32'(l3_resp_valid), 32'd1);
      check("t4_resp2_data", 32'(l3_resp_data), 32'd3);
      @(negedge clk);

      // Reset pulse mid-EXEC discards the operation.
      req0_a = 8'd2; req0_b = 8'd2; req0_cmd = 4'd0;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      check("t5_in_exec", 32'(alu_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_oe", 32'(alu_oe), 32'd0);
      check("t5_rst_alu_a", 32'(alu_a_in), 32'd0);
      check("t5_rst_resp_data", 32'(resp_data), 32'd0);
      check("t5_rst_ops_done", 32'(ops_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (resp_valid || alu_oe) seen++;
         @(negedge clk);
      end
      check("t5_no_resp", 32'(seen), 32'd0);
      check("t5_ops_done", 32'(ops_done), 32'd0);

      // Counter wrap: preload to 0xFFFF, one more completion lands on 0.
      force dut1.ops_done_q = 16'hFFFF;
      #1;
      release dut1.ops_done_q;
      @(negedge clk);
      req1_a = 8'd3; req1_b = 8'd1; req1_cmd = 4'd1;   // 2
      req1_valid = 1'b1;
      #1;
      check("t6_req1_ready", 32'(req1_ready), 32'd1);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      #1;
      check("t6_resp_data", 32'(resp_data), 32'd2);
      check("t6_resp_id", 32'(resp_id), 32'd1);
      @(negedge clk);
      #1;
      check("t6_wrap", 32'(ops_done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
